// File: rtl/ex_pkg.sv
// Shared definitions for the execute-stage issue controller: opcode
// constants, instruction classes, controller states and decode helpers.
package ex_pkg;

    localparam int REG_W = 5;

    localparam logic [6:0] OP_OP         = 7'b0110011;
    localparam logic [6:0] OP_LOAD       = 7'b0000011;
    localparam logic [6:0] OP_STORE      = 7'b0100011;
    localparam logic [6:0] OP_BRANCH     = 7'b1100011;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    typedef enum logic [1:0] {
        CLS_ALU,
        CLS_MD,
        CLS_LD,
        CLS_ST
    } instr_class_t;

    typedef enum logic [1:0] {
        IDLE,
        MD_BUSY,
        WB_HOLD
    } ex_state_t;

    // Route an instruction to the ALU, mul/div or load/store path.
    function automatic instr_class_t classify(input logic [6:0] opcode,
                                              input logic [6:0] funct7);
        instr_class_t cls;
        cls = CLS_ALU;
        if (opcode == OP_OP && funct7 == FUNCT7_MULDIV) begin
            cls = CLS_MD;
        end else if (opcode == OP_LOAD) begin
            cls = CLS_LD;
        end else if (opcode == OP_STORE) begin
            cls = CLS_ST;
        end
        return cls;
    endfunction

    // Stores and branches have no destination; x0 is never written.
    function automatic logic writes_rd(input logic [6:0]       opcode,
                                       input logic [REG_W-1:0] rd);
        return (opcode != OP_STORE) && (opcode != OP_BRANCH) && (rd != '0);
    endfunction

endpackage

// File: rtl/ex_issue_ctrl_if.sv
// Decode / memory / execute handshake bundle of the issue controller.
// master = decode and data-memory side, slave = the issue controller.
interface ex_issue_ctrl_if;
    import ex_pkg::*;

    logic             id_valid_in;
    logic             id_ready_out;
    logic [6:0]       opcode_in;
    logic [6:0]       funct7_in;
    logic [REG_W-1:0] rs1_in;
    logic [REG_W-1:0] rs2_in;
    logic [REG_W-1:0] rd_in;
    logic             flush_in;
    logic             mem_ack_in;
    logic             ex_stall_out;
    logic             ex_valid_out;
    logic             md_start_out;
    logic             rd_write_out;
    logic [REG_W-1:0] rd_out;
    logic             mem_err_out;

    modport master (
        output id_valid_in, opcode_in, funct7_in, rs1_in, rs2_in, rd_in,
               flush_in, mem_ack_in,
        input  id_ready_out, ex_stall_out, ex_valid_out, md_start_out,
               rd_write_out, rd_out, mem_err_out
    );

    modport slave (
        input  id_valid_in, opcode_in, funct7_in, rs1_in, rs2_in, rd_in,
               flush_in, mem_ack_in,
        output id_ready_out, ex_stall_out, ex_valid_out, md_start_out,
               rd_write_out, rd_out, mem_err_out
    );

endinterface

// File: rtl/ex_mem_scoreboard.sv
// Tracks the single outstanding load/store: busy flag, destination of a
// pending load, the ack timeout counter and the load-use/WAW hazard check.
module ex_mem_scoreboard
    import ex_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             issue_in,
    input  logic             is_load_in,
    input  logic [REG_W-1:0] rs1_in,
    input  logic [REG_W-1:0] rs2_in,
    input  logic [REG_W-1:0] rd_in,
    input  logic             mem_ack_in,
    output logic             busy_out,
    output logic [REG_W-1:0] ld_rd_out,
    output logic             hazard_out,
    output logic             done_out,
    output logic             timeout_out
);

    localparam logic [8:0] TIMEOUT_LIMIT = 9'(MEM_TIMEOUT);

    logic             busy_q,  busy_d;
    logic [REG_W-1:0] ld_rd_q, ld_rd_d;
    logic [7:0]       tcnt_q,  tcnt_d;
    logic [8:0]       tcnt_inc;
    logic [REG_W-1:0] src [3];
    logic [2:0]       src_match;

    // The incoming instruction's rs1, rs2 and rd are all compared against
    // the pending load destination; the rd term keeps writes in order.
    assign src[0] = rs1_in;
    assign src[1] = rs2_in;
    assign src[2] = rd_in;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_src_cmp
            assign src_match[gi] = (src[gi] == ld_rd_q);
        end
    endgenerate

    // tcnt_inc counts this cycle too, so the error fires when the access
    // has waited MEM_TIMEOUT cycles since it was issued.
    assign tcnt_inc    = {1'b0, tcnt_q} + 9'd1;
    assign done_out    = busy_q & mem_ack_in;
    assign timeout_out = busy_q & ~mem_ack_in & (tcnt_inc == TIMEOUT_LIMIT);
    assign hazard_out  = busy_q & (ld_rd_q != '0) & (|src_match);
    assign busy_out    = busy_q;
    assign ld_rd_out   = ld_rd_q;

    // Scoreboard next state: set on issue, clear on ack or timeout.
    always_comb begin
        busy_d  = busy_q;
        ld_rd_d = ld_rd_q;
        tcnt_d  = tcnt_q;
        if (issue_in) begin
            busy_d  = 1'b1;
            ld_rd_d = is_load_in ? rd_in : '0;
            tcnt_d  = '0;
        end else if (done_out || timeout_out) begin
            busy_d  = 1'b0;
            ld_rd_d = '0;
            tcnt_d  = '0;
        end else if (busy_q) begin
            tcnt_d  = tcnt_inc[7:0];
        end
    end

    // Scoreboard registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            busy_q  <= 1'b0;
            ld_rd_q <= '0;
            tcnt_q  <= '0;
        end else begin
            busy_q  <= busy_d;
            ld_rd_q <= ld_rd_d;
            tcnt_q  <= tcnt_d;
        end
    end

endmodule

// File: rtl/ex_issue_ctrl.sv
// Issue controller between decode and execute. Classifies each accepted
// instruction, sequences the multi-cycle mul/div path, arbitrates the
// writeback port between memory completions and ALU/MD completions, and
// drives the execute stall. No arithmetic is done here.
module ex_issue_ctrl
    import ex_pkg::*;
#(
    parameter int unsigned MD_LATENCY  = 32,
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic            req,
    input  logic            reset_n,
    ex_issue_ctrl_if.slave  bus
);

    localparam logic [5:0] MD_INIT = 6'(MD_LATENCY - 1);

    instr_class_t     cls;
    logic             is_mem;
    logic             wr_en;
    logic             id_ready;
    logic             fire;

    logic             sb_busy;
    logic [REG_W-1:0] sb_ld_rd;
    logic             sb_hazard;
    logic             sb_done;
    logic             sb_timeout;

    ex_state_t        state_q,    state_d;
    logic [5:0]       md_cnt_q,   md_cnt_d;
    logic [REG_W-1:0] pend_rd_q,  pend_rd_d;
    logic             pend_wr_q,  pend_wr_d;
    logic             valid_q,    valid_d;
    logic             stall_q,    stall_d;
    logic             wr_q,       wr_d;
    logic [REG_W-1:0] rd_q,       rd_d;
    logic             md_start_q, md_start_d;

    logic             exec_done;
    logic [REG_W-1:0] exec_rd;
    logic             exec_wr;

    assign cls    = classify(bus.opcode_in, bus.funct7_in);
    assign is_mem = (cls == CLS_LD) || (cls == CLS_ST);
    assign wr_en  = writes_rd(bus.opcode_in, bus.rd_in);

    // Accept only in IDLE, never during a flush, never on a load-use or
    // WAW hazard, and never a second memory op while one is outstanding.
    assign id_ready = reset_n & (state_q == IDLE) & ~bus.flush_in
                    & ~sb_hazard & ~(is_mem & sb_busy);
    assign fire     = bus.id_valid_in & id_ready;

    ex_mem_scoreboard #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_scoreboard (
        .clk         (req),
        .reset_n     (reset_n),
        .issue_in    (fire & is_mem),
        .is_load_in  (cls == CLS_LD),
        .rs1_in      (bus.rs1_in),
        .rs2_in      (bus.rs2_in),
        .rd_in       (bus.rd_in),
        .mem_ack_in  (bus.mem_ack_in),
        .busy_out    (sb_busy),
        .ld_rd_out   (sb_ld_rd),
        .hazard_out  (sb_hazard),
        .done_out    (sb_done),
        .timeout_out (sb_timeout)
    );

    // Next-state and next-output logic: FSM, mul/div countdown and
    // writeback arbitration where a memory completion always wins.
    always_comb begin
        state_d    = state_q;
        md_cnt_d   = md_cnt_q;
        pend_rd_d  = pend_rd_q;
        pend_wr_d  = pend_wr_q;
        md_start_d = 1'b0;
        exec_done  = 1'b0;
        exec_rd    = pend_rd_q;
        exec_wr    = pend_wr_q;
        valid_d    = 1'b0;
        stall_d    = 1'b1;
        wr_d       = 1'b0;
        rd_d       = '0;

        case (state_q)
            IDLE: begin
                if (fire && cls == CLS_ALU) begin
                    exec_done = 1'b1;
                    exec_rd   = bus.rd_in;
                    exec_wr   = wr_en;
                end else if (fire && cls == CLS_MD) begin
                    state_d    = MD_BUSY;
                    md_cnt_d   = MD_INIT;
                    md_start_d = 1'b1;
                    pend_rd_d  = bus.rd_in;
                    pend_wr_d  = wr_en;
                end
            end
            MD_BUSY: begin
                if (bus.flush_in) begin
                    state_d  = IDLE;
                    md_cnt_d = '0;
                end else if (md_cnt_q == 6'd1) begin
                    // Result is presented next cycle with the counter at 0.
                    exec_done = 1'b1;
                    state_d   = IDLE;
                    md_cnt_d  = '0;
                end else begin
                    md_cnt_d = md_cnt_q - 6'd1;
                end
            end
            WB_HOLD: begin
                exec_done = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (sb_done) begin
            valid_d = 1'b1;
            rd_d    = sb_ld_rd;
            wr_d    = (sb_ld_rd != '0);
            // A displaced ALU/MD result is parked and the stage stalls.
            stall_d = exec_done;
            if (exec_done) begin
                state_d   = WB_HOLD;
                pend_rd_d = exec_rd;
                pend_wr_d = exec_wr;
            end
        end else if (exec_done) begin
            valid_d = 1'b1;
            rd_d    = exec_rd;
            wr_d    = exec_wr;
            stall_d = 1'b0;
        end
    end

    // State, counter and registered execute-side outputs.
    always_ff @(posedge req) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            md_cnt_q   <= '0;
            pend_rd_q  <= '0;
            pend_wr_q  <= 1'b0;
            valid_q    <= 1'b0;
            stall_q    <= 1'b1;
            wr_q       <= 1'b0;
            rd_q       <= '0;
            md_start_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            md_cnt_q   <= md_cnt_d;
            pend_rd_q  <= pend_rd_d;
            pend_wr_q  <= pend_wr_d;
            valid_q    <= valid_d;
            stall_q    <= stall_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            md_start_q <= md_start_d;
        end
    end

    assign bus.id_ready_out = id_ready;
    assign bus.ex_stall_out = stall_q;
    assign bus.ex_valid_out = valid_q;
    assign bus.md_start_out = md_start_q;
    assign bus.rd_write_out = wr_q;
    assign bus.rd_out       = rd_q;
    assign bus.mem_err_out  = sb_timeout;

endmodule

// File: tb/tb_ex_issue_ctrl.sv
// Directed bench for ex_issue_ctrl with MD_LATENCY=32, MEM_TIMEOUT=8.
// Inputs change 2ns after each rising edge; outputs are checked 1ns later.
module tb_ex_issue_ctrl;

    localparam int OP_R   = 'b0110011;
    localparam int OP_I   = 'b0010011;
    localparam int OP_LD  = 'b0000011;
    localparam int OP_ST  = 'b0100011;
    localparam int OP_BR  = 'b1100011;
    localparam int F7_MD  = 'b0000001;

    logic req;
    logic reset_n;
    int   vectors;
    int   miscompares;

    ex_issue_ctrl_if bus ();

    ex_issue_ctrl #(
        .MD_LATENCY  (32),
        .MEM_TIMEOUT (8)
    ) dut (
        .req     (req),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial begin
        req = 1'b0;
        forever #5 req = ~req;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_o(input string tag, input int v, input int st, input int w,
                         input int r, input int ms, input int er);
        chk({tag, ".valid"},  32'(bus.ex_valid_out), 32'(v));
        chk({tag, ".stall"},  32'(bus.ex_stall_out), 32'(st));
        chk({tag, ".write"},  32'(bus.rd_write_out), 32'(w));
        chk({tag, ".mdstart"}, 32'(bus.md_start_out), 32'(ms));
        chk({tag, ".memerr"}, 32'(bus.mem_err_out),  32'(er));
        if (v != 0) chk({tag, ".rd"}, 32'(bus.rd_out), 32'(r));
    endtask

    task automatic drive(input int v, input int op, input int f7,
                         input int rs1, input int rs2, input int rd);
        bus.id_valid_in = 1'(v);
        bus.opcode_in   = 7'(op);
        bus.funct7_in   = 7'(f7);
        bus.rs1_in      = 5'(rs1);
        bus.rs2_in      = 5'(rs2);
        bus.rd_in       = 5'(rd);
    endtask

    task automatic cyc();
        @(posedge req);
        #2;
    endtask

    task automatic rdy(input string tag, input int exp);
        #1;
        chk(tag, 32'(bus.id_ready_out), 32'(exp));
    endtask

    initial begin
        vectors        = 0;
        miscompares    = 0;
        reset_n        = 1'b0;
        bus.flush_in   = 1'b0;
        bus.mem_ack_in = 1'b0;
        drive(1, OP_R, 0, 0, 0, 1);

        // Reset held two edges with an instruction presented.
        cyc();
        chk_o("rst1", 0, 1, 0, 0, 0, 0);
        chk("rst1.rd", 32'(bus.rd_out), 0);
        rdy("rst1.ready", 0);
        cyc();
        chk_o("rst2", 0, 1, 0, 0, 0, 0);
        chk("rst2.rd", 32'(bus.rd_out), 0);
        rdy("rst2.ready", 0);
        reset_n = 1'b1;
        rdy("rel.ready", 1);

        // Back-to-back ALU stream rd=1..4, then rd=0 and a branch.
        for (int i = 2; i <= 4; i++) begin
            cyc();
            chk_o($sformatf("alu%0d", i - 1), 1, 0, 1, i - 1, 0, 0);
            drive(1, OP_R, 0, 0, 0, i);
            rdy("alu.ready", 1);
        end
        cyc();
        chk_o("alu4", 1, 0, 1, 4, 0, 0);
        drive(1, OP_I, 0, 0, 0, 0);
        cyc();
        chk_o("alu.rd0", 1, 0, 0, 0, 0, 0);
        drive(1, OP_BR, 0, 1, 2, 5);
        cyc();
        chk_o("branch", 1, 0, 0, 5, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        cyc();
        chk_o("alu.idle", 0, 1, 0, 0, 0, 0);

        // MUL rd=5: start pulse next cycle, result 32 cycles after fire.
        drive(1, OP_R, F7_MD, 1, 2, 5);
        rdy("md.fire", 1);
        cyc();
        drive(0, 0, 0, 0, 0, 0);
        chk_o("md.start", 0, 1, 0, 0, 1, 0);
        rdy("md.busy.ready", 0);
        for (int k = 2; k <= 31; k++) begin
            cyc();
            chk($sformatf("md.wait%0d.valid", k), 32'(bus.ex_valid_out), 0);
            chk("md.wait.mdstart", 32'(bus.md_start_out), 0);
            rdy("md.wait.ready", 0);
        end
        cyc();
        chk_o("md.done", 1, 0, 1, 5, 0, 0);
        rdy("md.done.ready", 1);
        cyc();

        // MUL rd=6 flushed 10 cycles after fire: no writeback ever.
        drive(1, OP_R, F7_MD, 1, 2, 6);
        rdy("mdf.fire", 1);
        cyc();
        drive(0, 0, 0, 0, 0, 0);
        chk("mdf.start", 32'(bus.md_start_out), 1);
        for (int k = 2; k <= 10; k++) cyc();
        bus.flush_in = 1'b1;
        drive(1, OP_R, 0, 0, 0, 9);
        rdy("flush.ready", 0);
        cyc();
        bus.flush_in = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        rdy("flush.idle.ready", 1);
        chk("flush.dropalu", 32'(bus.ex_valid_out), 0);
        for (int k = 0; k < 25; k++) begin
            cyc();
            chk("flush.nowb", 32'(bus.ex_valid_out), 0);
        end

        // Load-use: LD rd=7, independent ADD issues, dependent ADD waits.
        drive(1, OP_LD, 0, 1, 0, 7);
        rdy("ld.fire", 1);
        cyc();
        chk("ld.nowb", 32'(bus.ex_valid_out), 0);
        drive(1, OP_R, 0, 3, 0, 9);
        rdy("indep.ready", 1);
        cyc();
        chk_o("indep.wb", 1, 0, 1, 9, 0, 0);
        drive(1, OP_R, 0, 7, 0, 8);
        rdy("ldu.hold", 0);
        cyc();
        drive(1, OP_R, 0, 3, 4, 7);
        rdy("waw.hold", 0);
        cyc();
        drive(1, OP_R, 0, 7, 0, 8);
        rdy("ldu.hold2", 0);
        cyc();
        bus.mem_ack_in = 1'b1;
        rdy("ldu.ackcyc", 0);
        cyc();
        bus.mem_ack_in = 1'b0;
        chk_o("ld.wb", 1, 0, 1, 7, 0, 0);
        rdy("ldu.accept", 1);
        cyc();
        chk_o("add.wb", 1, 0, 1, 8, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        cyc();

        // Store: second memory op held until the ack, store has no write.
        drive(1, OP_ST, 0, 1, 2, 10);
        rdy("st.fire", 1);
        cyc();
        drive(1, OP_LD, 0, 1, 0, 11);
        bus.mem_ack_in = 1'b1;
        rdy("ld.busy", 0);
        cyc();
        bus.mem_ack_in = 1'b0;
        chk_o("st.wb", 1, 0, 0, 0, 0, 0);
        rdy("ld2.fire", 1);

        // Collision: ack and ALU completion land on the same cycle.
        cyc();
        chk("coll.pre", 32'(bus.ex_valid_out), 0);
        drive(1, OP_I, 0, 1, 0, 12);
        bus.mem_ack_in = 1'b1;
        rdy("coll.alufire", 1);
        cyc();
        bus.mem_ack_in = 1'b0;
        drive(1, OP_I, 0, 1, 0, 13);
        chk_o("coll.mem", 1, 1, 1, 11, 0, 0);
        rdy("coll.ready", 0);
        cyc();
        chk_o("coll.alu", 1, 0, 1, 12, 0, 0);
        rdy("coll.after.ready", 1);
        cyc();
        chk_o("alu13", 1, 0, 1, 13, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        cyc();

        // Timeout: LD rd=14 never acked, error 8 cycles after fire.
        drive(1, OP_LD, 0, 1, 0, 14);
        rdy("tmo.fire", 1);
        for (int k = 1; k <= 7; k++) begin
            cyc();
            drive(1, OP_LD, 0, 2, 0, 15);
            rdy($sformatf("tmo.wait%0d.ready", k), 0);
            chk("tmo.wait.err", 32'(bus.mem_err_out), 0);
            chk("tmo.wait.valid", 32'(bus.ex_valid_out), 0);
        end
        cyc();
        rdy("tmo.errcyc.ready", 0);
        chk("tmo.err", 32'(bus.mem_err_out), 1);
        chk("tmo.errcyc.valid", 32'(bus.ex_valid_out), 0);
        cyc();
        rdy("tmo.next", 1);
        chk("tmo.err.pulse", 32'(bus.mem_err_out), 0);
        chk("tmo.nowb", 32'(bus.ex_valid_out), 0);
        cyc();
        drive(0, 0, 0, 0, 0, 0);
        bus.mem_ack_in = 1'b1;
        cyc();
        bus.mem_ack_in = 1'b0;
        chk_o("ld15.wb", 1, 0, 1, 15, 0, 0);

        // Reset in the middle of a MUL abandons it.
        cyc();
        drive(1, OP_R, F7_MD, 1, 2, 20);
        rdy("mr.fire", 1);
        cyc();
        drive(0, 0, 0, 0, 0, 0);
        cyc();
        cyc();
        reset_n = 1'b0;
        cyc();
        reset_n = 1'b1;
        chk_o("midrst", 0, 1, 0, 0, 0, 0);
        rdy("midrst.ready", 1);
        for (int k = 0; k < 35; k++) begin
            cyc();
            chk("midrst.nowb", 32'(bus.ex_valid_out), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ex_issue_ctrl.md
Name: ex_issue_ctrl

Overview:
Issue controller between decode and the execute stage of the RV32IM core. It accepts one decoded instruction per cycle and decides whether it goes through the single-cycle ALU path, the multi-cycle mul/div path, or the load/store path. It drives the execute stage's stall_in and the writeback enable, and tracks one outstanding memory access so that a dependent instruction cannot use a load result early. It owns sequencing only; no arithmetic.

Parameters:
MD_LATENCY, 32, cycles a mul/div op occupies the execute stage (valid range 2..63)
MEM_TIMEOUT, 255, cycles to wait for mem_ack_in before flagging an error (valid range 1..255)

Ports:
req  input  1  clock, rising edge
reset_n  input  1  synchronous active-low reset
id_valid_in  input  1  decode presents an instruction
id_ready_out  output  1  controller accepts the instruction this cycle (combinational)
opcode_in  input  7  instruction opcode
funct7_in  input  7  instruction funct7
rs1_in  input  5  source register 1 address
rs2_in  input  5  source register 2 address
rd_in  input  5  destination register address
flush_in  input  1  taken branch/jump: kill the not-yet-completed mul/div op
mem_ack_in  input  1  data memory completed the outstanding load/store
ex_stall_out  output  1  drives execute stall_in
ex_valid_out  output  1  execute result is valid this cycle (one-cycle pulse per instruction)
md_start_out  output  1  one-cycle pulse that starts the mul/div operand capture
rd_write_out  output  1  writeback enable, qualified with ex_valid_out
rd_out  output  5  writeback destination
mem_err_out  output  1  one-cycle pulse on load/store timeout

Behaviour:
- Reset (reset_n=0 at a rising edge of req):
  - state = IDLE; counters = 0; load scoreboard cleared.
  - ex_stall_out=1. ex_valid_out, md_start_out, rd_write_out and mem_err_out = 0. rd_out = 0.
  - Reset mid-op abandons any mul/div or memory access without producing a writeback.
- Instruction classes:
  - MD: opcode 0110011 with funct7=0000001.
  - LD: opcode 0000011.
  - ST: opcode 0100011.
  - ALU: every other opcode.
  - Writes rd: every class except ST and opcodes 1100011 and 0100011; rd=0 never writes.
- Accept: fire = id_valid_in & id_ready_out. Registered outputs update on the edge after fire.
- ALU fire:
  - Next cycle: ex_valid_out=1, ex_stall_out=0, rd_out=rd_in.
  - rd_write_out=1 if the instruction writes rd.
  - Latency is 1 cycle; back-to-back issue is allowed.
- MD fire:
  - Next cycle: md_start_out=1, ex_stall_out=1, state=MD_BUSY, counter=MD_LATENCY-1.
  - The counter decrements each cycle.
  - At counter==0: ex_valid_out=1 with writeback, ex_stall_out=0, state=IDLE.
  - Total latency from fire to ex_valid_out is MD_LATENCY cycles.
  - id_ready_out=0 while in MD_BUSY.
- LD/ST fire:
  - Allowed only when no access is outstanding; it sets the scoreboard (busy=1, ld_rd=rd_in for LD, 0 for ST).
  - The timeout counter resets to 0.
  - ALU and MD instructions may issue while an access is outstanding.
  - A second LD/ST is held (id_ready_out=0) until the scoreboard clears.
- mem_ack_in while busy:
  - Next cycle: ex_valid_out=1 and rd_out=ld_rd; rd_write_out=1 for LD with ld_rd!=0; scoreboard clears.
  - mem_ack_in while not busy is ignored.
- Load-use hazard: id_ready_out=0 while busy and ld_rd!=0 and (rs1_in==ld_rd or rs2_in==ld_rd or rd_in==ld_rd). The rd_in term prevents WAW reordering.
- Writeback collision (ack and ALU/MD completion due in the same cycle):
  - The memory completion wins.
  - The ALU/MD completion is held one cycle with ex_stall_out=1.
  - id_ready_out=0 during the hold cycle.
- Timeout:
  - The counter increments each cycle while busy without ack.
  - When it reaches MEM_TIMEOUT: mem_err_out pulses, the scoreboard clears, and there is no writeback.
- flush_in:
  - In MD_BUSY, or in the cycle an MD is fired: return to IDLE and clear the counter. No ex_valid_out and no writeback.
  - An ALU fire in the same cycle as flush_in is dropped.
  - An outstanding memory access is NOT killed; it completes normally.
  - While flush_in=1, id_ready_out=0.
- ex_stall_out=1 whenever no result is presented that cycle.

Decomposition:
- ex_pkg holds:
  - opcode constants OP_OP, OP_LOAD, OP_STORE, OP_BRANCH, and FUNCT7_MULDIV;
  - typedef instr_class_t {CLS_ALU, CLS_MD, CLS_LD, CLS_ST};
  - typedef ex_state_t {IDLE, MD_BUSY, WB_HOLD}.
- One sub-module, ex_mem_scoreboard, owns the outstanding-access flag, ld_rd, the timeout counter and the hazard compare.
- The FSM and MD counter stay in ex_issue_ctrl.

Test Plan:
- Reset: hold reset_n=0 for 2 cycles with id_valid_in=1 -> ex_stall_out=1, all pulses 0, id_ready_out=0 during reset. First instruction is accepted on the cycle after release.
- ALU stream: 4 back-to-back ALU ops, rd=1..4 -> ex_valid_out high 4 consecutive cycles, rd_out=1,2,3,4. An op with rd=0 gives rd_write_out=0.
- MD op: fire MUL rd=5 with MD_LATENCY=32 -> md_start_out at cycle+1, ex_valid_out with rd_out=5 exactly 32 cycles after fire, id_ready_out=0 in between. Flush at cycle 10 -> no writeback, IDLE next cycle.
- Load-use: LD rd=7, then ADD rs1=7 -> ADD held until mem_ack_in (delayed 5 cycles), LD writeback rd=7 first, ADD accepted the next cycle. An independent ADD rs1=3 issues immediately.
- Collision: ack arrives in the same cycle an ALU op would complete -> LD writeback first, ALU writeback one cycle later, id_ready_out=0 for that cycle.
- Timeout: LD with no ack, MEM_TIMEOUT=8 -> mem_err_out pulse 8 cycles after fire, no writeback, the next LD is accepted the following cycle.
